ifu_prefetch: RTL
=================

Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit for the RV32 core. It replaces the bare PC register plus combinational instruction read with a decoupled, pipelined fetch path. It owns the fetch PC and issues in-order requests to instruction memory over a valid/ready channel with multiple outstanding requests. Responses are buffered in a DEPTH-entry prefetch FIFO, and a valid/ready instruction stream is presented to decode. Redirects from branch/jump resolution flush the buffer and drop stale in-flight responses.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
RESET_PC, 32'h8000_0000, fetch PC after reset
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max requests accepted by memory without response (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored (treated as 0)
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  XLEN  word-aligned fetch address
mem_rsp_valid  input  1  response valid (in order, always accepted)
mem_rsp_data  input  ILEN  fetched instruction
mem_rsp_err  input  1  access fault for this response
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst_data  output  ILEN  instruction word
inst_pc  output  XLEN  PC of inst_data
inst_err  output  1  fetch fault flag for this instruction

Behaviour:
- Reset (rst_n low, async):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs: mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, inst_err=0.
- Request issue:
  - mem_req_valid = !redirect_valid && (outstanding < MAX_OUTSTANDING) && (fifo_count + outstanding - drop_cnt < DEPTH). This credit rule guarantees every non-dropped response has a FIFO slot.
  - mem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
  - Address and valid are held while waiting for ready, except that a redirect deasserts valid that cycle.
- Response:
  - Each mem_rsp_valid decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt -= 1.
  - Otherwise {data, err, pc} is pushed into the FIFO. The response PC comes from an internal rsp_pc counter that starts at the same value as fetch_pc and advances by 4 per kept response.
  - Same-cycle request and response handshakes update outstanding by net 0.
- Output:
  - inst_* reflect the FIFO head (registered FIFO); inst_valid = !empty.
  - Minimum latency is 1 cycle: mem_rsp_valid in cycle N gives inst_valid in N+1.
  - Pop on inst_valid && inst_ready. Simultaneous push and pop with FIFO full is legal.
  - inst_err does not stop fetch; decode traps on it.
- Redirect (priority over all other updates in that cycle):
  - fetch_pc and rsp_pc are set to {redirect_pc[XLEN-1:2],2'b00}.
  - FIFO is flushed, and any pop that cycle is ignored.
  - drop_cnt = outstanding (including a response arriving that cycle, which is itself dropped, net of its decrement).
  - First new request is issued the next cycle.
  - Back-to-back redirects: the last one wins, and drop_cnt accumulates correctly.
- Overflow of the FIFO or of outstanding is unreachable by construction. Verification asserts this, and asserts that no response arrives with outstanding==0.

Decomposition:
- Package ifu_pkg: XLEN, ILEN, INST_BYTES=4, RESET_PC_DEFAULT=32'h8000_0000, and the fifo entry struct {pc, data, err}.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH; push, pop, flush, full, empty, count; async active-low reset). It is instantiated once for the prefetch buffer.
- Top-level core instantiation replaces the PC register and the instruction read path.

Test Plan:
- Reset release, mem_req_ready=1, response 1 cycle after each request, inst_ready=1 -> first mem_req_addr=0x8000_0000; inst_pc stream 0x8000_0000, 0x8000_0004, 0x8000_0008, with one instruction per cycle at steady state.
- inst_ready=0 with DEPTH=4 -> exactly 4 requests issued, then mem_req_valid=0. One pop -> exactly one further request.
- Redirect to 0x8000_0103 with 2 requests outstanding -> both responses dropped, next mem_req_addr=0x8000_0100, and the first inst_pc after redirect is 0x8000_0100.
- Response with mem_rsp_err=1 at addr 0x8000_0008 -> inst_err=1 for exactly that inst_pc, and fetch continues at 0x8000_000C.
- mem_req_ready held low 5 cycles -> mem_req_addr is stable and nothing is issued beyond MAX_OUTSTANDING.
- rst_n asserted mid-stream with FIFO half full -> outputs are 0 immediately (asynchronously), and after release the fetch restarts at 0x8000_0000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ifu_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // One prefetch buffer slot: the instruction, its fault flag and its PC.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] data;
        logic            err;
    } fifo_entry_t;

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// Generic synchronous FIFO with flush, registered storage and occupancy count.
// Latency: a push is visible at pop_data on the cycle after it is accepted.
// Backpressure: push while full is accepted only together with a pop; flush wins over push/pop.
//
// Ports: clk, rst_n (async, active low); push/push_data in; pop in, pop_data out (head);
//        flush clears the queue; full, empty, count report occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their natural width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until count says the slot is live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Decoupled instruction fetch: owns the fetch PC, issues pipelined memory requests, buffers responses.
// Latency: response in cycle N is presented to decode in cycle N+1; first request one cycle after reset release.
// Backpressure: requests are credit-limited so every kept response has a buffer slot; decode stalls via inst_ready.
//
// Ports: redirect_valid/redirect_pc flush and restart fetch; mem_req_* is the valid/ready request channel;
//        mem_rsp_* returns in-order responses (always accepted); inst_* is the valid/ready stream to decode.
module ifu_prefetch #(
    parameter int              XLEN            = ifu_pkg::XLEN,
    parameter int              ILEN            = ifu_pkg::ILEN,
    parameter logic [XLEN-1:0] RESET_PC        = ifu_pkg::RESET_PC_DEFAULT,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err
);

    import ifu_pkg::fifo_entry_t;
    import ifu_pkg::INST_BYTES;

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);

    // Held low through reset and the first edge after it, so no request leaves
    // while the core is still in reset.
    logic            run_q;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outstanding_nxt;
    // Responses still in flight that belong to a fetch stream abandoned by a redirect.
    logic [OW-1:0]   drop_cnt;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            rsp_keep;
    logic            req_fire;
    logic            out_ok;
    logic            credit_ok;
    logic [XLEN-1:0] redirect_base;
    fifo_entry_t     push_entry;
    fifo_entry_t     head_entry;

    assign redirect_base = redirect_pc & ~XLEN'(3);

    // Slots already promised = buffered + in flight - in flight but to be dropped.
    // Issuing only while that stays below DEPTH means a kept response always fits.
    assign out_ok    = (int'(outstanding) < MAX_OUTSTANDING);
    assign credit_ok = ((int'(fifo_count) + int'(outstanding) - int'(drop_cnt)) < DEPTH);

    assign mem_req_valid = run_q && !redirect_valid && out_ok && credit_ok;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response landing in a redirect cycle belongs to the old stream.
    assign rsp_keep = mem_rsp_valid && !redirect_valid && (drop_cnt == '0);

    // Redirect flushes the buffer, so a pop in the same cycle is meaningless.
    assign fifo_pop = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !mem_rsp_valid) begin
            outstanding_nxt = outstanding + OW'(1);
        end else if (!req_fire && mem_rsp_valid) begin
            outstanding_nxt = outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run_q       <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                // Everything still in flight after this cycle is stale; repeated
                // redirects re-evaluate this, so the count never double-counts.
                drop_cnt <= outstanding_nxt;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + XLEN'(INST_BYTES);
                end
                if (mem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
            end
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = rsp_pc;
        push_entry.data = mem_rsp_data;
        push_entry.err  = mem_rsp_err;
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_prefetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Storage is not reset, so the outputs are forced to zero while nothing is buffered.
    assign inst_valid = !fifo_empty;
    assign inst_data  = fifo_empty ? '0 : head_entry.data;
    assign inst_pc    = fifo_empty ? '0 : head_entry.pc;
    assign inst_err   = fifo_empty ? 1'b0 : head_entry.err;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_rsp_valid && (outstanding == '0)));
            assert (!(req_fire && !mem_rsp_valid && (int'(outstanding) == MAX_OUTSTANDING)));
            assert (!(rsp_keep && fifo_full && !fifo_pop));
        end
    end

endmodule
